// File: rtl/mem_arb_ctrl.sv
// mem_arb_ctrl
//   Owns the single byte-wide RAM port. Arbitrates between instruction fetch
//   (IF) and the load/store stage (MEM), breaks 1/2/4-byte accesses into byte
//   cycles, assembles read data little-endian, and produces the 6-bit pipeline
//   stall vector from its own busy status plus the ID load-use request.
//
// Ports
//   clk, rst (async, active low), rdy (low freezes everything)
//   if_req/if_addr            -> if_done/if_inst       fetch word (always 4 bytes)
//   mem_req/mem_we/mem_len/
//   mem_addr/mem_wdata        -> mem_done/mem_rdata    load/store 1, 2 or 4 bytes
//   flush_i                   branch mispredict from EX
//   stallreq_id               load-use hazard from ID
//   ram_a/ram_wr/ram_dout     RAM address/strobe/write byte; ram_din read byte
//                             (returned one cycle after its address)
//   stall                     bit0 PC .. bit5 WB, 1 = stop
//
// Build option
//   FLUSH_ABORT_EN  defined: a flush aborts an in-flight fetch and blocks the
//                   IF grant in IDLE. Undefined: the fetch completes but its
//                   if_done is suppressed.

module mem_arb_ctrl #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [2:0]        mem_len,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic              flush_i,
  input  logic              stallreq_id,
  input  logic [7:0]        ram_din,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  output logic              if_done,
  output logic [31:0]       if_inst,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic [5:0]        stall
);

  typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  len_q, len_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic        byte_held_q, byte_held_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
`ifndef FLUSH_ABORT_EN
  logic        flush_seen_q, flush_seen_d;
`endif

  logic              reading;
  logic              rd_fresh;
  logic              rd_last;
  logic              wr_last;
  logic              if_mask;
  logic              if_grant_ok;
  logic [1:0]        rd_lane;
  logic [31:0]       word_asm;
  logic [ADDR_W-1:0] addr_cur;
  logic [7:0]        wr_byte;

  // Datapath helpers. The byte on ram_din belongs to the address presented
  // in the previous cycle, i.e. lane cnt-1. If rdy drops, the first frozen
  // edge still captures that byte (byte_held_q) because the RAM keeps reading
  // the held address and ram_din would otherwise be overwritten with the
  // wrong byte before the FSM resumes.
  always_comb begin
    reading  = (state_q == IF_RD) || (state_q == MEM_RD);
    rd_fresh = reading && (cnt_q != 3'd0) && !byte_held_q;
    rd_lane  = 2'(cnt_q - 3'd1);
    word_asm = buf_q;
    if (rd_fresh) begin
      word_asm[{rd_lane, 3'b000} +: 8] = ram_din;
    end
    addr_cur = ADDR_W'(base_q + {29'd0, cnt_q});
    wr_byte  = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
    rd_last  = (cnt_q >= len_q);
    wr_last  = (({1'b0, cnt_q} + 4'd1) >= {1'b0, len_q});
    byte_held_d = !rdy && (byte_held_q || rd_fresh);
`ifdef FLUSH_ABORT_EN
    if_mask     = flush_i;
    if_grant_ok = !flush_i;
`else
    if_mask      = flush_seen_q || flush_i;
    if_grant_ok  = 1'b1;
    flush_seen_d = flush_seen_q;
    if (state_q == IDLE) begin
      flush_seen_d = 1'b0;
    end else if ((state_q == IF_RD) && flush_i) begin
      flush_seen_d = 1'b1;
    end
`endif
  end

  // Next-state and port outputs. MEM wins the IDLE grant because it holds the
  // older instruction; grants are never preempted. Done pulses and the final
  // read byte are combinational so the pipeline advances on the done edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    ram_a       = '0;
    ram_wr      = 1'b0;
    ram_dout    = 8'd0;
    if_done     = 1'b0;
    mem_done    = 1'b0;
    if_inst     = if_inst_q;
    mem_rdata   = mem_rdata_q;

    case (state_q)
      IDLE: begin
        cnt_d = 3'd0;
        if (mem_req) begin
          state_d = mem_we ? MEM_WR : MEM_RD;
          len_d   = mem_len;
          base_d  = mem_addr;
          wdata_d = mem_wdata;
          buf_d   = '0;
        end else if (if_req && if_grant_ok) begin
          state_d = IF_RD;
          len_d   = 3'd4;
          base_d  = if_addr;
          buf_d   = '0;
        end
      end

      IF_RD, MEM_RD: begin
        buf_d = word_asm;
        if (!rd_last) begin
          ram_a = addr_cur;
          cnt_d = cnt_q + 3'd1;
        end else begin
          state_d = IDLE;
          cnt_d   = 3'd0;
          if (state_q == MEM_RD) begin
            mem_done    = 1'b1;
            mem_rdata   = word_asm;
            mem_rdata_d = word_asm;
          end else if (!if_mask) begin
            if_done   = 1'b1;
            if_inst   = word_asm;
            if_inst_d = word_asm;
          end
        end
`ifdef FLUSH_ABORT_EN
        if ((state_q == IF_RD) && flush_i) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end
`endif
      end

      MEM_WR: begin
        ram_a    = addr_cur;
        ram_wr   = 1'b1;
        ram_dout = wr_byte;
        if (wr_last) begin
          mem_done = 1'b1;
          state_d  = IDLE;
          cnt_d    = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    // A frozen cycle must neither write RAM nor report completion.
    if (!rdy) begin
      ram_wr    = 1'b0;
      if_done   = 1'b0;
      mem_done  = 1'b0;
      if_inst   = if_inst_q;
      mem_rdata = mem_rdata_q;
    end
  end

  // Stall priority: outstanding MEM access, then ID hazard, then fetch.
  always_comb begin
    if (mem_req && !mem_done) begin
      stall = 6'b011111;
    end else if (stallreq_id) begin
      stall = 6'b000111;
    end else if (if_req && !if_done) begin
      stall = 6'b000011;
    end else begin
      stall = 6'b000000;
    end
  end

  // State registers. The read buffer and its held flag keep updating while
  // rdy is low so a byte already in flight is not lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      len_q        <= 3'd0;
      base_q       <= '0;
      wdata_q      <= '0;
      buf_q        <= '0;
      byte_held_q  <= 1'b0;
      if_inst_q    <= '0;
      mem_rdata_q  <= '0;
`ifndef FLUSH_ABORT_EN
      flush_seen_q <= 1'b0;
`endif
    end else begin
      buf_q       <= buf_d;
      byte_held_q <= byte_held_d;
      if (rdy) begin
        state_q      <= state_d;
        cnt_q        <= cnt_d;
        len_q        <= len_d;
        base_q       <= base_d;
        wdata_q      <= wdata_d;
        if_inst_q    <= if_inst_d;
        mem_rdata_q  <= mem_rdata_d;
`ifndef FLUSH_ABORT_EN
        flush_seen_q <= flush_seen_d;
`endif
      end
    end
  end

endmodule
